// File: rtl/frame_upsampler.sv
// frame_upsampler
// Expands a compact flattened sample vector to a full flattened frame using
// nearest-neighbour index mapping, pixel j <- sample floor(j*S/F). The frame
// is written one pixel per accepted stream beat. The same pixels are also
// presented on a valid/ready stream that honours backpressure.
module frame_upsampler #(
  parameter int SAMPLE_COUNT = 256,
  parameter int FRAME_COUNT  = 784,
  parameter int DATA_WIDTH   = 16,
  localparam int IDX_W = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DATA_WIDTH*SAMPLE_COUNT-1:0] sample_flat,
  output logic [DATA_WIDTH*FRAME_COUNT-1:0]  frame_flat,
  output logic [DATA_WIDTH-1:0]             pix_data,
  output logic [IDX_W-1:0]                  pix_index,
  output logic                              pix_last,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int SRC_W = (SAMPLE_COUNT > 1) ? $clog2(SAMPLE_COUNT) : 1;
  localparam int ACC_W = $clog2(FRAME_COUNT) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_COUNT - 1);
  localparam logic [SRC_W-1:0] SRC_MAX  = SRC_W'(SAMPLE_COUNT - 1);
  localparam logic [ACC_W-1:0] ACC_STEP = ACC_W'(SAMPLE_COUNT);
  localparam logic [ACC_W-1:0] ACC_WRAP = ACC_W'(FRAME_COUNT);

  // Elaboration-time sanity check of the size parameters.
  if (SAMPLE_COUNT == 0 || FRAME_COUNT == 0 || SAMPLE_COUNT > FRAME_COUNT) begin : g_param_err
    $error("frame_upsampler: need 0 < SAMPLE_COUNT <= FRAME_COUNT");
  end

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] latch_q [SAMPLE_COUNT];
  logic [DATA_WIDTH-1:0] frame_q [FRAME_COUNT];
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic [SRC_W-1:0]      src_idx_q, src_idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
  logic                  done_q, done_d;
  logic                  load, xfer, at_last;

  assign at_last   = (out_idx_q == LAST_IDX);
  assign pix_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign pix_data  = latch_q[src_idx_q];
  assign pix_index = out_idx_q;
  assign pix_last  = at_last && pix_valid;
  assign done      = done_q;

  // Next-state logic: start acceptance, beat transfer and the Bresenham-style
  // accumulator that steps the source index without multiply or divide.
  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    src_idx_d = src_idx_q;
    acc_d     = acc_q;
    done_d    = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    acc_sum   = acc_q + ACC_STEP;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = STREAM;
          load      = 1'b1;
          out_idx_d = '0;
          src_idx_d = '0;
          acc_d     = '0;
        end
      end
      STREAM: begin
        if (pix_ready) begin
          xfer = 1'b1;
          if (acc_sum >= ACC_WRAP) begin
            acc_d = acc_sum - ACC_WRAP;
            if (src_idx_q != SRC_MAX) src_idx_d = src_idx_q + 1'b1;
          end else begin
            acc_d = acc_sum;
          end
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_idx_q <= '0;
      src_idx_q <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
      src_idx_q <= src_idx_d;
      acc_q     <= acc_d;
      done_q    <= done_d;
    end
  end

  // Sample snapshot taken on the accepted start edge so later input changes
  // cannot disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLE_COUNT; i++) latch_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < SAMPLE_COUNT; i++)
        latch_q[i] <= sample_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Frame storage; each accepted beat writes its pixel, stale data stays
  // until overwritten in index order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < FRAME_COUNT; j++) frame_q[j] <= '0;
    end else if (xfer) begin
      frame_q[out_idx_q] <= latch_q[src_idx_q];
    end
  end

  for (genvar j = 0; j < FRAME_COUNT; j++) begin : g_flat
    assign frame_flat[j*DATA_WIDTH +: DATA_WIDTH] = frame_q[j];
  end

endmodule

// File: tb/tb_frame_upsampler.sv
// Self-checking bench for frame_upsampler: three instances (4->10, 256->784
// default, 8->8 identity) compared against an arithmetic nearest-neighbour model.
module tb_frame_upsampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   sel   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  // instance 0: 4 -> 10
  logic [63:0]    s0 = '0;
  logic [159:0]   f0;
  logic [15:0]    pd0;
  logic [3:0]     pi0;
  logic           pl0, pv0, b0, d0, st0;
  // instance 1: 256 -> 784
  logic [4095:0]  s1 = '0;
  logic [12543:0] f1;
  logic [15:0]    pd1;
  logic [9:0]     pi1;
  logic           pl1, pv1, b1, d1, st1;
  // instance 2: 8 -> 8
  logic [127:0]   s2 = '0;
  logic [127:0]   f2;
  logic [15:0]    pd2;
  logic [2:0]     pi2;
  logic           pl2, pv2, b2, d2, st2;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  frame_upsampler #(.SAMPLE_COUNT(4), .FRAME_COUNT(10), .DATA_WIDTH(16)) u_small (
    .clk(clk), .rst_n(rst_n), .start(st0), .sample_flat(s0), .frame_flat(f0),
    .pix_data(pd0), .pix_index(pi0), .pix_last(pl0), .pix_valid(pv0),
    .pix_ready(ready), .busy(b0), .done(d0));

  frame_upsampler #(.SAMPLE_COUNT(256), .FRAME_COUNT(784), .DATA_WIDTH(16)) u_def (
    .clk(clk), .rst_n(rst_n), .start(st1), .sample_flat(s1), .frame_flat(f1),
    .pix_data(pd1), .pix_index(pi1), .pix_last(pl1), .pix_valid(pv1),
    .pix_ready(ready), .busy(b1), .done(d1));

  frame_upsampler #(.SAMPLE_COUNT(8), .FRAME_COUNT(8), .DATA_WIDTH(16)) u_id (
    .clk(clk), .rst_n(rst_n), .start(st2), .sample_flat(s2), .frame_flat(f2),
    .pix_data(pd2), .pix_index(pi2), .pix_last(pl2), .pix_valid(pv2),
    .pix_ready(ready), .busy(b2), .done(d2));

  // view of the selected instance's stream
  logic        mv, ml, md;
  logic [15:0] mdata;
  int          midx;
  always_comb begin
    mv = 1'b0; ml = 1'b0; md = 1'b0; mdata = '0; midx = 0;
    case (sel)
      0: begin mv = pv0; ml = pl0; md = d0; mdata = pd0; midx = int'(pi0); end
      1: begin mv = pv1; ml = pl1; md = d1; mdata = pd1; midx = int'(pi1); end
      default: begin mv = pv2; ml = pl2; md = d2; mdata = pd2; midx = int'(pi2); end
    endcase
  end

  // reference model: pixel j comes from sample floor(j*S/F)
  function automatic int msrc(input int j, input int s, input int f);
    return (j * s) / f;
  endfunction

  logic [15:0] bd[$];
  int          bi[$];
  bit          bl[$];
  int          done_cyc, done_w, stall_err, first_vcyc;
  logic [15:0] es[8];

  // Drive one frame on the selected instance, recording accepted beats.
  task automatic run_frame(input int F, input bit do_start, input bit rnd,
                           input int start_at, input bit scramble, input bit chain);
    bit          pst;
    logic [15:0] pdat;
    int          pidx;
    bd.delete(); bi.delete(); bl.delete();
    done_cyc = -1; done_w = 0; stall_err = 0; first_vcyc = -1; pst = 0;
    pdat = '0; pidx = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 3*F + 20; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (pst && (!mv || mdata !== pdat || midx !== pidx)) stall_err++;
      if (md) begin
        done_cyc = cyc;
        break;
      end
      if (mv && first_vcyc < 0) first_vcyc = cyc;
      pst = mv && !ready; pdat = mdata; pidx = midx;
      if (mv && ready) begin
        bd.push_back(mdata); bi.push_back(midx); bl.push_back(ml);
        if (start_at == midx) start = 1'b1;
        if (scramble && midx == 5) s0 = {$urandom, $urandom};
      end
    end
    ready = 1'b1;
    if (done_cyc > 0) begin
      if (chain) start = 1'b1;
      else begin
        @(negedge clk);
        #1;
        done_w = md ? 2 : 1;
      end
    end
  endtask

  task automatic load_small();
    for (int k = 0; k < 4; k++) begin
      es[k] = 16'($urandom);
      s0[k*16 +: 16] = es[k];
    end
  endtask

  // Shared 4->10 expectations are re-derived inline in each test from es[].
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({b0, pv0, d0} !== 3'b000) $display("FAIL reset_ctrl got busy/valid/done=%b want 000", {b0, pv0, d0});
    else n_pass++;
    n_checks++;
    if (f0 !== '0 || pi0 !== 4'd0) $display("FAIL reset_frame got frame=%h idx=%0d want 0", f0, pi0);
    else n_pass++;
    n_checks++;
    if ({b1, pv1, b2, pv2} !== 4'b0000) $display("FAIL reset_other got %b want 0000", {b1, pv1, b2, pv2});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_small_stream();
    int bad, lastbad;
    sel = 0;
    load_small();
    run_frame(10, 1, 0, -1, 0, 0);
    n_checks++;
    if (done_cyc !== 11) $display("FAIL small_latency got %0d want 11", done_cyc);
    else n_pass++;
    n_checks++;
    if (done_w !== 1) $display("FAIL small_done_width got %0d want 1", done_w);
    else n_pass++;
    n_checks++;
    if (bd.size() !== 10) $display("FAIL small_beat_count got %0d want 10", bd.size());
    else n_pass++;
    bad = 0; lastbad = 0;
    for (int j = 0; j < bd.size(); j++) begin
      if (bd[j] !== es[msrc(j, 4, 10)] || bi[j] !== j) bad++;
      if (bl[j] !== (j == 9)) lastbad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL small_beats got %0d bad beats want 0", bad);
    else n_pass++;
    n_checks++;
    if (lastbad != 0) $display("FAIL small_last got %0d bad pix_last want 0", lastbad);
    else n_pass++;
    bad = 0;
    for (int j = 0; j < 10; j++) if (f0[j*16 +: 16] !== es[msrc(j, 4, 10)]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL small_frame got %0d bad pixels want 0", bad);
    else n_pass++;
  endtask

  task automatic test_default();
    int bad;
    sel = 1;
    for (int i = 0; i < 256; i++) s1[i*16 +: 16] = 16'(i);
    run_frame(784, 1, 0, -1, 0, 0);
    n_checks++;
    if (bd.size() !== 784) $display("FAIL def_beat_count got %0d want 784", bd.size());
    else n_pass++;
    if (bd.size() == 784) begin
      n_checks++;
      if (bd[3] !== 16'd0 || bd[4] !== 16'd1 || bd[783] !== 16'd255)
        $display("FAIL def_corners got p3=%0d p4=%0d p783=%0d want 0 1 255", bd[3], bd[4], bd[783]);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc !== 785 || done_w !== 1) $display("FAIL def_done got cyc=%0d width=%0d want 785 1", done_cyc, done_w);
    else n_pass++;
    bad = 0;
    for (int j = 0; j < 784; j++) if (f1[j*16 +: 16] !== 16'(msrc(j, 256, 784))) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL def_frame got %0d bad pixels want 0", bad);
    else n_pass++;
  endtask

  task automatic test_identity();
    int bad;
    sel = 2;
    for (int k = 0; k < 8; k++) begin
      es[k] = 16'($urandom);
      s2[k*16 +: 16] = es[k];
    end
    run_frame(8, 1, 0, -1, 0, 0);
    bad = 0;
    for (int j = 0; j < 8; j++) begin
      if (j >= bd.size() || bd[j] !== es[j]) bad++;
      if (f2[j*16 +: 16] !== es[j]) bad++;
    end
    n_checks++;
    if (bad != 0 || done_cyc !== 9) $display("FAIL identity got %0d bad, done_cyc=%0d want 0, 9", bad, done_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad;
    sel = 0;
    load_small();
    run_frame(10, 1, 1, -1, 1, 0);
    n_checks++;
    if (stall_err != 0) $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err);
    else n_pass++;
    bad = (bd.size() == 10) ? 0 : 1;
    for (int j = 0; j < bd.size(); j++)
      if (bd[j] !== es[msrc(j, 4, 10)] || bi[j] !== j) bad++;
    for (int j = 0; j < 10; j++) if (f0[j*16 +: 16] !== es[msrc(j, 4, 10)]) bad++;
    n_checks++;
    if (bad != 0 || done_cyc < 11) $display("FAIL bp_stream got %0d bad, done_cyc=%0d want 0, >=11", bad, done_cyc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad;
    sel = 0;
    load_small();
    run_frame(10, 1, 0, 5, 0, 1);
    bad = (bd.size() == 10) ? 0 : 1;
    for (int j = 0; j < bd.size(); j++) if (bd[j] !== es[msrc(j, 4, 10)]) bad++;
    n_checks++;
    if (bad != 0 || done_cyc !== 11) $display("FAIL b2b_ignore got %0d bad, done_cyc=%0d want 0, 11", bad, done_cyc);
    else n_pass++;
    load_small();
    run_frame(10, 0, 0, -1, 0, 0);
    n_checks++;
    if (first_vcyc !== 1 || bi.size() == 0 || bi[0] !== 0)
      $display("FAIL b2b_first got first_valid_cycle=%0d want 1 with index 0", first_vcyc);
    else n_pass++;
    bad = (bd.size() == 10) ? 0 : 1;
    for (int j = 0; j < bd.size(); j++) if (bd[j] !== es[msrc(j, 4, 10)]) bad++;
    n_checks++;
    if (bad != 0 || done_cyc !== 11) $display("FAIL b2b_second got %0d bad, done_cyc=%0d want 0, 11", bad, done_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int  bad;
    bit  found, saw_done;
    sel = 0;
    load_small();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (pv0 && pi0 == 4'd3) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL midrst_reach got no index 3 want index 3 within 20 cycles");
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({b0, pv0, d0} !== 3'b000 || f0 !== '0)
      $display("FAIL midrst_state got busy/valid/done=%b frame=%h want 000 and 0", {b0, pv0, d0}, f0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (15) begin
      @(negedge clk); #1;
      if (d0) saw_done = 1;
    end
    n_checks++;
    if (saw_done) $display("FAIL midrst_nodone got done=1 want 0");
    else n_pass++;
    load_small();
    run_frame(10, 1, 0, -1, 0, 0);
    bad = (bd.size() == 10) ? 0 : 1;
    for (int j = 0; j < bd.size(); j++) if (bd[j] !== es[msrc(j, 4, 10)]) bad++;
    for (int j = 0; j < 10; j++) if (f0[j*16 +: 16] !== es[msrc(j, 4, 10)]) bad++;
    n_checks++;
    if (bad != 0 || done_cyc !== 11) $display("FAIL midrst_fresh got %0d bad, done_cyc=%0d want 0, 11", bad, done_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_small_stream();
    test_default();
    test_identity();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_upsampler.md
# frame_upsampler

Expands a compact flattened sample vector (for example the 256-entry generator output) back to the full flattened frame width (for example 784 pixels for 28x28). Each frame pixel is a nearest-neighbour copy of one sample, chosen by evenly spaced index mapping. It is the inverse-direction companion of the frame down-sampler that feeds the discriminator. Besides the full flat frame, the block emits pixels serially over a valid/ready stream for display and serial dump paths, with backpressure.

## Interface
Parameters:
- SAMPLE_COUNT, 256, number of input samples; must be non-zero and ≤ FRAME_COUNT.
- FRAME_COUNT, 784, number of output frame pixels; must be non-zero.
- DATA_WIDTH, 16, bits per sample/pixel.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request to expand `sample_flat`; accepted only when idle.
- sample_flat  in  DATA_WIDTH*SAMPLE_COUNT  input samples; sample i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- frame_flat  out  DATA_WIDTH*FRAME_COUNT  expanded frame; pixel j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- pix_data  out  DATA_WIDTH  current stream pixel.
- pix_index  out  clog2(FRAME_COUNT)  frame index of `pix_data`.
- pix_last  out  1  high with the final pixel (index FRAME_COUNT-1).
- pix_valid  out  1  stream beat valid.
- pix_ready  in  1  downstream accepts the beat.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE: busy=0, pix_valid=0.
  - STREAM: busy=1, pix_valid=1.
- Transitions:
  - IDLE→STREAM when `start` is sampled high. The same edge snapshots `sample_flat` into an internal latch and clears out_idx, src_idx and acc to 0.
  - In STREAM, a beat transfers on every edge where pix_valid && pix_ready. On transfer:
    - `frame_flat[out_idx]` ← `latch[src_idx]`.
    - If out_idx == FRAME_COUNT-1: go to IDLE and pulse `done`.
    - Otherwise, advance out_idx.
  - `start` while in STREAM is ignored; there is no queuing.
- Mapping: pixel j takes sample floor(j*SAMPLE_COUNT/FRAME_COUNT). This is implemented with an accumulator, with no multiplier or divider. Per transfer:
  - acc ← acc + SAMPLE_COUNT.
  - If the new acc ≥ FRAME_COUNT: acc −= FRAME_COUNT and src_idx += 1. At most one increment per step.
  - acc needs clog2(FRAME_COUNT)+1 bits.
  - src_idx is clamped to SAMPLE_COUNT-1.
- Combinational outputs:
  - pix_data = latch[src_idx].
  - pix_index = out_idx.
  - pix_last = (out_idx == FRAME_COUNT-1) && pix_valid.
- Frame contents:
  - `frame_flat` is not cleared at start; stale pixels are overwritten in index order.
  - `frame_flat` is fully valid only once `done` is high.
- Input independence: changes to `sample_flat` after the start edge do not affect the current frame.
- Parameter check (simulation only): report an error if either count is zero or SAMPLE_COUNT > FRAME_COUNT.

## Timing
- Reset (rst_n low at an edge):
  - frame_flat = 0, latch = 0.
  - pix_valid = 0, busy = 0, done = 0.
  - out_idx = 0, src_idx = 0, acc = 0.
  - State = IDLE.
  - Reset overrides `start` and aborts a frame mid-stream; no `done` is issued for the aborted frame.
- Start sampled at edge E:
  - busy and pix_valid are high from E+1, with pix_index = 0.
- With pix_ready held high:
  - Beat j transfers at edge E+1+j.
  - After edge E+FRAME_COUNT, busy = 0, pix_valid = 0 and done = 1 for exactly one cycle.
  - Start-to-done latency is FRAME_COUNT+1 cycles.
- Backpressure:
  - pix_ready low stalls all indices.
  - pix_data, pix_index and pix_valid stay stable until the transfer.
- Back-to-back frames:
  - `start` may be high in the same cycle as `done`; it is accepted because the state is IDLE.
  - The next frame's first beat follows one cycle later.
- Transfer condition: pix_ready with pix_valid low has no effect.

## Test plan
- SAMPLE_COUNT=4, FRAME_COUNT=10, samples {A,B,C,D}, pix_ready=1 → stream A,A,A,B,B,C,C,C,D,D on indices 0..9; pix_last only on index 9; done 11 cycles after the start edge; frame_flat matches the stream.
- Defaults with sample i = i → pixels 0..3 = 0, pixel 4 = 1, pixel 783 = 255; exactly 784 beats; done pulse one cycle wide.
- SAMPLE_COUNT=FRAME_COUNT=8 → identity: pixel j = sample j.
- Random pix_ready (≈50%) with 4/10 → beat order and values identical to the ready=1 run; pix_data and pix_index stable while stalled; sample_flat changed mid-frame has no effect.
- start pulsed at index 5 of a running frame → ignored, frame completes normally. Then start asserted in the done cycle → new frame begins, index 0 valid on the next cycle.
- rst_n low at index 3 → next cycle busy=0, pix_valid=0, done=0, frame_flat=0. A fresh start then produces a correct full frame.
